// File: rtl/btle_rx_phase_ctrl_pkg.sv
// Shared constants for the BTLE receive phase controller: FSM encoding,
// access-address length and the advertising-channel default access address.
package btle_rx_phase_ctrl_pkg;

  localparam int unsigned AA_LEN = 32;
  localparam logic [AA_LEN-1:0] DEFAULT_AA = 32'h8E89_BED6;

  // FSM encoding kept as plain constants so older tools can consume it
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Next sampling phase with wrap at the last phase of a symbol
  function automatic logic [15:0] next_phase(input logic [15:0] cur, input logic [15:0] last);
    logic [15:0] nxt;
    if (cur == last) begin
      nxt = 16'd0;
    end else begin
      nxt = cur + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btle_rx_phase_ctrl_aa_correlator.sv
// One access-address correlator: a 32-bit LSB-first shift register plus a
// look-ahead comparator that reports whether the bit being shifted in now
// completes the target access address.
module btle_aa_correlator
  import btle_rx_phase_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_bit,
  input  logic [AA_LEN-1:0] i_aa,
  output logic              o_match
);

  logic [AA_LEN-1:0] r_sr;
  logic [AA_LEN-1:0] w_sr_nxt;

  // New bits enter at the MSB so that after 32 shifts bit 0 holds the first bit on air
  assign w_sr_nxt = {i_bit, r_sr[AA_LEN-1:1]};

  // Match is evaluated on the post-shift value so the controller can react in the same cycle
  assign o_match = i_shift & (w_sr_nxt == i_aa);

  // Shift register with synchronous clear; clear wins over shift
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr <= {AA_LEN{1'b0}};
    end else if (i_clr) begin
      r_sr <= {AA_LEN{1'b0}};
    end else if (i_shift) begin
      r_sr <= w_sr_nxt;
    end else begin
      r_sr <= r_sr;
    end
  end

endmodule

// File: rtl/btle_rx_phase_ctrl.sv
// BTLE receive phase controller: one access-address correlator per sampling
// phase, locks to the first phase that matches, then decimates to one bit per
// symbol for the programmed payload length and signals packet end.
module btle_rx_phase_ctrl
  import btle_rx_phase_ctrl_pkg::*;
#(
  parameter int SAMPLE_PER_SYMBOL = 8,
  parameter int PHASE_WIDTH       = 3,
  parameter int LEN_BIT_WIDTH     = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [AA_LEN-1:0]        access_address,
  input  logic [LEN_BIT_WIDTH-1:0] payload_bit_len,
  input  logic                     phy_bit,
  input  logic                     bit_valid,
  output logic                     hit,
  output logic [PHASE_WIDTH-1:0]   locked_phase,
  output logic                     bit_out,
  output logic                     bit_out_valid,
  output logic                     pkt_done,
  output logic                     busy
);

  // Sample counter only needs to reach the point where every phase has seen a full AA window
  localparam int unsigned SAMPLE_THRESH = AA_LEN * SAMPLE_PER_SYMBOL - 1;
  localparam int          SCNT_W        = $clog2(AA_LEN * SAMPLE_PER_SYMBOL);
  localparam logic [SCNT_W-1:0]      SCNT_MAX   = SCNT_W'(SAMPLE_THRESH);
  localparam logic [PHASE_WIDTH-1:0] PHASE_LAST = PHASE_WIDTH'(SAMPLE_PER_SYMBOL - 1);

  logic [1:0]               r_state;
  logic [PHASE_WIDTH-1:0]   r_phase_cnt;
  logic [SCNT_W-1:0]        r_sample_cnt;
  logic [LEN_BIT_WIDTH-1:0] r_bit_cnt;
  logic [LEN_BIT_WIDTH-1:0] r_len_q;
  logic [PHASE_WIDTH-1:0]   r_locked_phase;
  logic                     r_hit;
  logic                     r_bit_out;
  logic                     r_bit_out_valid;
  logic                     r_pkt_done;
  logic                     r_busy;

  logic [1:0]               w_state_nxt;
  logic [PHASE_WIDTH-1:0]   w_phase_nxt;
  logic [PHASE_WIDTH-1:0]   w_phase_adv;
  logic [SCNT_W-1:0]        w_scnt_nxt;
  logic [LEN_BIT_WIDTH-1:0] w_bit_cnt_nxt;
  logic [LEN_BIT_WIDTH-1:0] w_len_nxt;
  logic [PHASE_WIDTH-1:0]   w_lp_nxt;
  logic                     w_hit_nxt;
  logic                     w_bout_nxt;
  logic                     w_bov_nxt;
  logic                     w_pkt_nxt;

  logic [SAMPLE_PER_SYMBOL-1:0] w_shift;
  logic [SAMPLE_PER_SYMBOL-1:0] w_match;
  logic                         w_match_sel;
  logic                         w_clr;

  // Correlators are wiped whenever the controller is between search attempts
  assign w_clr = (r_state == ST_IDLE) | (r_state == ST_DONE);

  assign w_phase_adv = PHASE_WIDTH'(next_phase(16'(r_phase_cnt), 16'(PHASE_LAST)));

  genvar g;
  generate
    for (g = 0; g < SAMPLE_PER_SYMBOL; g++) begin : g_corr
      // Only the correlator owning the current phase shifts on a valid sample
      assign w_shift[g] = (r_state == ST_SEARCH) & en & bit_valid & (r_phase_cnt == PHASE_WIDTH'(g));

      btle_aa_correlator u_corr (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_clr),
        .i_shift (w_shift[g]),
        .i_bit   (phy_bit),
        .i_aa    (access_address),
        .o_match (w_match[g])
      );
    end
  endgenerate

  // Select the match flag of the phase being sampled this cycle
  always_comb begin
    w_match_sel = 1'b0;
    for (int i = 0; i < SAMPLE_PER_SYMBOL; i++) begin
      w_match_sel = w_match_sel | ((r_phase_cnt == PHASE_WIDTH'(i)) & w_match[i]);
    end
  end

  // Next-state and next-output logic for the search/lock/decimate sequence
  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase_cnt;
    w_scnt_nxt    = r_sample_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_len_nxt     = r_len_q;
    w_lp_nxt      = r_locked_phase;
    w_hit_nxt     = 1'b0;
    w_bout_nxt    = r_bit_out;
    w_bov_nxt     = 1'b0;
    w_pkt_nxt     = 1'b0;
    if (!en) begin
      // Silent abort: no pulses, locked_phase kept for diagnostics
      w_state_nxt   = ST_IDLE;
      w_phase_nxt   = {PHASE_WIDTH{1'b0}};
      w_scnt_nxt    = {SCNT_W{1'b0}};
      w_bit_cnt_nxt = {LEN_BIT_WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_phase_nxt   = {PHASE_WIDTH{1'b0}};
          w_scnt_nxt    = {SCNT_W{1'b0}};
          w_bit_cnt_nxt = {LEN_BIT_WIDTH{1'b0}};
          w_state_nxt   = ST_SEARCH;
        end
        ST_SEARCH: begin
          if (bit_valid) begin
            w_phase_nxt = w_phase_adv;
            if (r_sample_cnt < SCNT_MAX) begin
              w_scnt_nxt = r_sample_cnt + SCNT_W'(1);
            end else begin
              w_scnt_nxt = r_sample_cnt;
            end
            // Guard: a match only counts once every register holds real samples
            if (w_match_sel && (r_sample_cnt >= SCNT_MAX)) begin
              w_hit_nxt     = 1'b1;
              w_lp_nxt      = r_phase_cnt;
              w_len_nxt     = payload_bit_len;
              w_bit_cnt_nxt = {LEN_BIT_WIDTH{1'b0}};
              w_state_nxt   = ST_LOCKED;
            end else begin
              w_state_nxt = ST_SEARCH;
            end
          end else begin
            w_state_nxt = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (bit_valid) begin
            w_phase_nxt = w_phase_adv;
          end else begin
            w_phase_nxt = r_phase_cnt;
          end
          if (r_bit_cnt == r_len_q) begin
            // Length reached (or zero): finish without consuming a sample
            w_state_nxt = ST_DONE;
            w_pkt_nxt   = 1'b1;
          end else if (bit_valid && (r_phase_cnt == r_locked_phase)) begin
            w_bout_nxt    = phy_bit;
            w_bov_nxt     = 1'b1;
            w_bit_cnt_nxt = r_bit_cnt + LEN_BIT_WIDTH'(1);
          end else begin
            w_state_nxt = ST_LOCKED;
          end
        end
        ST_DONE: begin
          w_phase_nxt   = {PHASE_WIDTH{1'b0}};
          w_scnt_nxt    = {SCNT_W{1'b0}};
          w_bit_cnt_nxt = {LEN_BIT_WIDTH{1'b0}};
          w_state_nxt   = ST_SEARCH;
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State, counters and registered outputs with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_IDLE;
      r_phase_cnt     <= {PHASE_WIDTH{1'b0}};
      r_sample_cnt    <= {SCNT_W{1'b0}};
      r_bit_cnt       <= {LEN_BIT_WIDTH{1'b0}};
      r_len_q         <= {LEN_BIT_WIDTH{1'b0}};
      r_locked_phase  <= {PHASE_WIDTH{1'b0}};
      r_hit           <= 1'b0;
      r_bit_out       <= 1'b0;
      r_bit_out_valid <= 1'b0;
      r_pkt_done      <= 1'b0;
      r_busy          <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_phase_cnt     <= w_phase_nxt;
      r_sample_cnt    <= w_scnt_nxt;
      r_bit_cnt       <= w_bit_cnt_nxt;
      r_len_q         <= w_len_nxt;
      r_locked_phase  <= w_lp_nxt;
      r_hit           <= w_hit_nxt;
      r_bit_out       <= w_bout_nxt;
      r_bit_out_valid <= w_bov_nxt;
      r_pkt_done      <= w_pkt_nxt;
      r_busy          <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign hit           = r_hit;
  assign locked_phase  = r_locked_phase;
  assign bit_out       = r_bit_out;
  assign bit_out_valid = r_bit_out_valid;
  assign pkt_done      = r_pkt_done;
  assign busy          = r_busy;

endmodule

// File: tb/tb_btle_rx_phase_ctrl.sv
// Directed bench for btle_rx_phase_ctrl: 8x-oversampled packets with known
// access address and payload, checked against hand-derived expectations.
module tb_btle_rx_phase_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] access_address;
  logic [11:0] payload_bit_len;
  logic        phy_bit;
  logic        bit_valid;
  logic        hit;
  logic [2:0]  locked_phase;
  logic        bit_out;
  logic        bit_out_valid;
  logic        pkt_done;
  logic        busy;

  int n_vec;
  int n_miss;
  int step_cnt;
  int n_hit, hit_step, hit_lp, busy_at_hit;
  int n_bov, last_bov_step, n_pkt, pkt_step;
  int aa_end_step;
  logic [31:0] got_bits;
  logic [7:0]  rst_snap;

  btle_rx_phase_ctrl #(
    .SAMPLE_PER_SYMBOL (8),
    .PHASE_WIDTH       (3),
    .LEN_BIT_WIDTH     (12)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .access_address  (access_address),
    .payload_bit_len (payload_bit_len),
    .phy_bit         (phy_bit),
    .bit_valid       (bit_valid),
    .hit             (hit),
    .locked_phase    (locked_phase),
    .bit_out         (bit_out),
    .bit_out_valid   (bit_out_valid),
    .pkt_done        (pkt_done),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_stats();
    n_hit = 0; hit_step = -1; hit_lp = -1; busy_at_hit = -1;
    n_bov = 0; last_bov_step = -1; n_pkt = 0; pkt_step = -1;
    aa_end_step = -2; got_bits = 32'h0; rst_snap = 8'hFF;
  endtask

  // One clock: drive inputs, let the edge pass, then record outputs
  task automatic step(input logic b, input logic v);
    phy_bit = b;
    bit_valid = v;
    @(posedge clk);
    #1;
    step_cnt++;
    if (hit) begin
      n_hit++; hit_step = step_cnt; hit_lp = int'(locked_phase); busy_at_hit = int'(busy);
    end
    if (bit_out_valid) begin
      if (n_bov < 32) got_bits[n_bov] = bit_out;
      n_bov++;
      last_bov_step = step_cnt;
    end
    if (pkt_done) begin
      n_pkt++; pkt_step = step_cnt;
    end
  endtask

  task automatic rearm();
    en = 1'b0; step(1'b0, 1'b0);
    en = 1'b1; step(1'b0, 1'b0);
  endtask

  // Preamble 0xD6, AA, payload; each bit as 8 samples, phases in inv are inverted
  task automatic send_pkt(input logic [7:0] inv, input logic [15:0] pay, input int nbits,
                          input int exp_ph, input bit gaps, input int abort_at, input int rst_at);
    logic [55:0] bits;
    bit rst_done;
    bits = {pay, access_address, 8'hD6};
    rst_done = 1'b0;
    for (int i = 0; i < 40 + nbits; i++) begin
      for (int p = 0; p < 8; p++) begin
        if (gaps && ($urandom_range(0, 1) == 1)) step(1'b0, 1'b0);
        step(bits[i] ^ inv[p], 1'b1);
        if (i == 39 && p == exp_ph) aa_end_step = step_cnt;
        if (abort_at >= 0 && n_bov == abort_at && en) en = 1'b0;
        if (rst_at >= 0 && n_bov == rst_at && !rst_done) begin
          rst = 1'b1;
          step(1'b0, 1'b0);
          rst_snap = {hit, locked_phase, bit_out, bit_out_valid, pkt_done, busy};
          rst = 1'b0;
          rst_done = 1'b1;
        end
      end
    end
    for (int k = 0; k < 16; k++) step(1'b0, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0; step_cnt = 0;
    access_address = 32'h8E89BED6;
    payload_bit_len = 12'd16;
    rst = 1'b1; en = 1'b0; phy_bit = 1'b0; bit_valid = 1'b0;
    clr_stats();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("rst_hit", 32'(hit), 32'h0);
    chk("rst_locked_phase", 32'(locked_phase), 32'h0);
    chk("rst_bit_out", 32'(bit_out), 32'h0);
    chk("rst_bit_out_valid", 32'(bit_out_valid), 32'h0);
    chk("rst_pkt_done", 32'(pkt_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

    // Ideal eye, every phase valid: phase 0 completes first
    clr_stats(); rearm();
    send_pkt(8'h00, 16'hA5C3, 16, 0, 1'b0, -1, -1);
    chk("ideal_n_hit", n_hit, 1);
    chk("ideal_hit_latency", hit_step, aa_end_step);
    chk("ideal_locked_phase", hit_lp, 0);
    chk("ideal_busy_at_hit", busy_at_hit, 1);
    chk("ideal_n_bits", n_bov, 16);
    chk("ideal_bits", got_bits, 32'h0000A5C3);
    chk("ideal_n_pkt", n_pkt, 1);
    chk("ideal_pkt_after_last", pkt_step, last_bov_step + 1);
    chk("ideal_busy_end", 32'(busy), 32'h0);

    // Phases 0-2 and 6-7 inverted: only phases 3..5 carry the AA, 3 first
    clr_stats(); rearm();
    send_pkt(8'hC7, 16'h3C5A, 16, 3, 1'b0, -1, -1);
    chk("corrupt_n_hit", n_hit, 1);
    chk("corrupt_locked_phase", hit_lp, 3);
    chk("corrupt_hit_latency", hit_step, aa_end_step);
    chk("corrupt_bits", got_bits, 32'h00003C5A);
    chk("corrupt_n_pkt", n_pkt, 1);

    // Zero-length payload: DONE straight after the hit cycle
    clr_stats(); rearm();
    payload_bit_len = 12'd0;
    send_pkt(8'h00, 16'h0000, 0, 0, 1'b0, -1, -1);
    chk("len0_n_hit", n_hit, 1);
    chk("len0_pkt_after_hit", pkt_step, hit_step + 1);
    chk("len0_n_bits", n_bov, 0);
    chk("len0_n_pkt", n_pkt, 1);
    payload_bit_len = 12'd16;

    // Drop enable after 5 payload bits: silent abort
    clr_stats(); rearm();
    send_pkt(8'h00, 16'hA5C3, 16, 0, 1'b0, 5, -1);
    chk("abort_n_bits", n_bov, 5);
    chk("abort_n_pkt", n_pkt, 0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_locked_phase_kept", 32'(locked_phase), 32'h0);
    clr_stats(); rearm();
    send_pkt(8'h00, 16'h5AA5, 16, 0, 1'b0, -1, -1);
    chk("rearm_n_hit", n_hit, 1);
    chk("rearm_bits", got_bits, 32'h00005AA5);

    // Reset for one cycle while locked on phase 3
    clr_stats(); rearm();
    send_pkt(8'hC7, 16'hA5C3, 16, 3, 1'b0, -1, 3);
    chk("midrst_outputs", 32'(rst_snap), 32'h0);
    chk("midrst_n_pkt", n_pkt, 0);
    chk("midrst_n_bits", n_bov, 3);

    // Same ideal packet with random idle gaps: results unchanged
    clr_stats(); rearm();
    send_pkt(8'h00, 16'hA5C3, 16, 0, 1'b1, -1, -1);
    chk("gap_n_hit", n_hit, 1);
    chk("gap_locked_phase", hit_lp, 0);
    chk("gap_hit_latency", hit_step, aa_end_step);
    chk("gap_bits", got_bits, 32'h0000A5C3);
    chk("gap_pkt_after_last", pkt_step, last_bov_step + 1);

    // Long random stream without the AA, with gaps: never a hit
    clr_stats(); rearm();
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 1) == 1) step(1'b0, 1'b0);
      step(1'($urandom_range(0, 1)), 1'b1);
    end
    chk("noise_n_hit", n_hit, 0);
    chk("noise_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
